// File: rtl/multibyte_instruction_register.sv
// Instruction register that assembles an opcode byte plus up to MAX_OPERANDS operand bytes
// from the W bus, and drives a selected field back onto the bus through a registered output.
module multibyte_instruction_register #(
  parameter int DATA_W       = 8,
  parameter int OPCODE_W     = 4,
  parameter int MAX_OPERANDS = 2,
  parameter int CNT_W        = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load_n,
  input  logic                           output_n,
  input  logic                           clear,
  input  logic [DATA_W-1:0]              w_bus_in,
  input  logic [CNT_W-1:0]               operand_count,
  input  logic [CNT_W-1:0]               out_sel,
  output logic [DATA_W-1:0]              w_bus_out,
  output logic                           w_bus_oe,
  output logic [OPCODE_W-1:0]            opcode,
  output logic [MAX_OPERANDS*DATA_W-1:0] operand,
  output logic                           instr_valid,
  output logic                           busy,
  output logic                           len_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPERANDS);

  typedef enum logic [1:0] {IDLE, FETCH, COMPLETE} state_t;

  state_t            state;
  logic [DATA_W-1:0] opcode_byte;
  logic [DATA_W-1:0] operand_bytes [MAX_OPERANDS];
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  capture_target;
  logic              capture_err;
  logic [DATA_W-1:0] sel_byte;

  // Oversized operand counts saturate so the fetch always terminates.
  always_comb begin
    capture_err    = (operand_count > MAX_CNT);
    capture_target = capture_err ? MAX_CNT : operand_count;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opcode_byte <= '0;
      for (int i = 0; i < MAX_OPERANDS; i++) operand_bytes[i] <= '0;
      idx         <= '0;
      target      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      idx         <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (!load_n) begin
      case (state)
        IDLE, COMPLETE: begin
          opcode_byte <= w_bus_in;
          for (int i = 0; i < MAX_OPERANDS; i++) operand_bytes[i] <= '0;
          target  <= capture_target;
          len_err <= capture_err;
          idx     <= '0;
          if (capture_target == '0) begin
            state       <= COMPLETE;
            instr_valid <= 1'b1;
            busy        <= 1'b0;
          end else begin
            state       <= FETCH;
            instr_valid <= 1'b0;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          for (int i = 0; i < MAX_OPERANDS; i++)
            if (idx == CNT_W'(i)) operand_bytes[i] <= w_bus_in;
          if (idx == target - 1'b1) begin
            state       <= COMPLETE;
            instr_valid <= 1'b1;
            busy        <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Field select reads the pre-load contents, so a same-cycle load shows up one cycle later.
  always_comb begin
    sel_byte = '0;
    if (out_sel == '0) sel_byte = DATA_W'(opcode_byte[DATA_W-OPCODE_W-1:0]);
    for (int i = 0; i < MAX_OPERANDS; i++)
      if (out_sel == CNT_W'(i + 1)) sel_byte = operand_bytes[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_bus_out <= '0;
      w_bus_oe  <= 1'b0;
    end else begin
      w_bus_oe  <= ~output_n;
      w_bus_out <= output_n ? '0 : sel_byte;
    end
  end

  assign opcode = opcode_byte[DATA_W-1 -: OPCODE_W];

  for (genvar g = 0; g < MAX_OPERANDS; g++) begin : g_operand
    assign operand[g*DATA_W +: DATA_W] = operand_bytes[g];
  end

endmodule

// File: tb/tb_multibyte_instruction_register.sv
// Directed bench for multibyte_instruction_register at default parameters; expected
// values are hand-computed and checked with immediate assertions.
module tb_multibyte_instruction_register;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_n = 1'b1;
  logic        output_n = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  w_bus_in = '0;
  logic [1:0]  operand_count = '0;
  logic [1:0]  out_sel = '0;
  logic [7:0]  w_bus_out;
  logic        w_bus_oe;
  logic [3:0]  opcode;
  logic [15:0] operand;
  logic        instr_valid;
  logic        busy;
  logic        len_err;

  int checks = 0;
  int fails  = 0;

  multibyte_instruction_register dut (
    .clock(clock), .reset(reset), .load_n(load_n), .output_n(output_n), .clear(clear),
    .w_bus_in(w_bus_in), .operand_count(operand_count), .out_sel(out_sel),
    .w_bus_out(w_bus_out), .w_bus_oe(w_bus_oe), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .busy(busy), .len_err(len_err)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, then let a rising edge pass and settle.
  task automatic apply_stimulus(input logic ld_n, input logic out_n, input logic clr,
                                input logic [7:0] bus, input logic [1:0] cnt,
                                input logic [1:0] sel);
    load_n = ld_n; output_n = out_n; clear = clr;
    w_bus_in = bus; operand_count = cnt; out_sel = sel;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    // Reset state
    #12;
    check_output("rst_opcode",  32'(opcode), 32'h0);
    check_output("rst_operand", 32'(operand), 32'h0);
    check_output("rst_oe",      32'(w_bus_oe), 32'h0);
    check_output("rst_out",     32'(w_bus_out), 32'h0);
    check_output("rst_valid",   32'(instr_valid), 32'h0);
    check_output("rst_busy",    32'(busy), 32'h0);
    check_output("rst_lenerr",  32'(len_err), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Zero-operand instruction and opcode-byte embedded field
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h3A, 2'd0, 2'd0);
    check_output("op0_opcode", 32'(opcode), 32'h3);
    check_output("op0_valid",  32'(instr_valid), 32'h1);
    check_output("op0_busy",   32'(busy), 32'h0);
    check_output("op0_oe",     32'(w_bus_oe), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0);
    check_output("op0_out",    32'(w_bus_out), 32'h0A);
    check_output("op0_oe_hi",  32'(w_bus_oe), 32'h1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0);
    check_output("idle_oe",    32'(w_bus_oe), 32'h0);
    check_output("idle_out",   32'(w_bus_out), 32'h0);

    // Two-operand instruction
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hC5, 2'd2, 2'd0);
    check_output("op2_opcode", 32'(opcode), 32'hC);
    check_output("op2_busy1",  32'(busy), 32'h1);
    check_output("op2_valid1", 32'(instr_valid), 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h34, 2'd0, 2'd0);
    check_output("op2_busy2",  32'(busy), 32'h1);
    check_output("op2_opnd1",  32'(operand), 32'h0034);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h12, 2'd0, 2'd0);
    check_output("op2_busy3",  32'(busy), 32'h0);
    check_output("op2_valid3", 32'(instr_valid), 32'h1);
    check_output("op2_opnd2",  32'(operand), 32'h1234);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd2);
    check_output("sel2_out",   32'(w_bus_out), 32'h12);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd1);
    check_output("sel1_out",   32'(w_bus_out), 32'h34);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd3);
    check_output("sel3_out",   32'(w_bus_out), 32'h00);
    check_output("sel3_oe",    32'(w_bus_oe), 32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0);
    check_output("sel0_out",   32'(w_bus_out), 32'h05);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0);
    check_output("hold_valid", 32'(instr_valid), 32'h1);
    check_output("hold_opnd",  32'(operand), 32'h1234);

    // Oversized count saturates; operand_count ignored while fetching; load_n high holds
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h80, 2'd3, 2'd0);
    check_output("len_err",    32'(len_err), 32'h1);
    check_output("len_busy",   32'(busy), 32'h1);
    check_output("len_opcode", 32'(opcode), 32'h8);
    check_output("len_clr_op", 32'(operand), 32'h0000);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'hEE, 2'd0, 2'd0);
    check_output("fhold_busy", 32'(busy), 32'h1);
    check_output("fhold_opnd", 32'(operand), 32'h0000);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hAB, 2'd0, 2'd0);
    check_output("len_busy2",  32'(busy), 32'h1);
    check_output("len_opnd1",  32'(operand), 32'h00AB);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hCD, 2'd0, 2'd0);
    check_output("len_valid",  32'(instr_valid), 32'h1);
    check_output("len_opnd2",  32'(operand), 32'hCDAB);
    check_output("len_err2",   32'(len_err), 32'h1);

    // Clear mid-fetch beats load_n and keeps contents
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hC5, 2'd2, 2'd0);
    check_output("new_lenerr", 32'(len_err), 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h34, 2'd0, 2'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h99, 2'd0, 2'd0);
    check_output("clr_valid",  32'(instr_valid), 32'h0);
    check_output("clr_busy",   32'(busy), 32'h0);
    check_output("clr_opnd",   32'(operand), 32'h0034);
    check_output("clr_opcode", 32'(opcode), 32'hC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h3A, 2'd0, 2'd0);
    check_output("aclr_opcode", 32'(opcode), 32'h3);
    check_output("aclr_valid", 32'(instr_valid), 32'h1);
    check_output("aclr_opnd",  32'(operand), 32'h0000);

    // len_err survives clear, cleared by next capture
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h80, 2'd3, 2'd0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 2'd0);
    check_output("clr_lenerr", 32'(len_err), 32'h1);
    check_output("clr_busy2",  32'(busy), 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h3A, 2'd0, 2'd0);
    check_output("cap_lenerr", 32'(len_err), 32'h0);

    // Same-cycle load and output sees old contents; clear leaves bus path alone
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h77, 2'd0, 2'd0);
    check_output("same_out",   32'(w_bus_out), 32'h0A);
    check_output("same_opcode", 32'(opcode), 32'h7);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0);
    check_output("next_out",   32'(w_bus_out), 32'h07);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 2'd0);
    check_output("clrbus_out", 32'(w_bus_out), 32'h07);
    check_output("clrbus_oe",  32'(w_bus_oe), 32'h1);

    // Asynchronous reset during fetch
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'hC5, 2'd2, 2'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h34, 2'd0, 2'd1);
    check_output("pre_busy",   32'(busy), 32'h1);
    check_output("pre_oe",     32'(w_bus_oe), 32'h1);
    load_n = 1'b1; output_n = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_output("arst_opcode", 32'(opcode), 32'h0);
    check_output("arst_opnd",  32'(operand), 32'h0);
    check_output("arst_busy",  32'(busy), 32'h0);
    check_output("arst_valid", 32'(instr_valid), 32'h0);
    check_output("arst_oe",    32'(w_bus_oe), 32'h0);
    check_output("arst_out",   32'(w_bus_out), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h3A, 2'd0, 2'd0);
    check_output("post_opcode", 32'(opcode), 32'h3);
    check_output("post_valid", 32'(instr_valid), 32'h1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
